// File: rtl/stereo_window_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | stereo_window_buffer: WIN x WIN sliding windows over a stereo pair     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module stereo_window_buffer #(
  parameter int PIX_W = 8,
  parameter int WIN   = 5,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                       i_clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic                       i_sof,
  input  logic [PIX_W-1:0]           i_left_pix,
  input  logic [PIX_W-1:0]           i_right_pix,
  output logic [WIN*WIN*PIX_W-1:0]   o_win_l,
  output logic [WIN*WIN*PIX_W-1:0]   o_win_r,
  output logic                       o_valid,
  output logic [15:0]                o_row,
  output logic [15:0]                o_col,
  output logic                       o_eof,
  output logic                       o_frame_err
);

  localparam int HALF     = (WIN - 1) / 2;
  localparam int WIN_BITS = WIN * WIN * PIX_W;
  localparam int COL_AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [15:0]       row_q, row_d, col_q, col_d;
  logic [15:0]       cur_row, cur_col;

  logic              s1_valid_q, s1_valid_d;
  logic [PIX_W-1:0]  s1_l_q, s1_l_d, s1_r_q, s1_r_d;
  logic [15:0]       s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic              s1_eof_q, s1_eof_d, s1_err_q, s1_err_d;

  logic [WIN_BITS-1:0] win_l_q, win_l_d, win_r_q, win_r_d;
  logic [WIN_BITS-1:0] out_win_l_q, out_win_l_d, out_win_r_q, out_win_r_d;
  logic                out_valid_q, out_valid_d, out_eof_q, out_eof_d, out_err_q, out_err_d;
  logic [15:0]         out_row_q, out_row_d, out_col_q, out_col_d;

  logic [WIN*PIX_W-1:0] col_l, col_r;
  logic [COL_AW-1:0]    col_idx;
  logic                 qualify;

  // Line buffers: entry 0 is the oldest stored line; no reset needed.
  logic [PIX_W-1:0] lb_l [WIN-1][IMG_W];
  logic [PIX_W-1:0] lb_r [WIN-1][IMG_W];

  // Stage 1: frame tracking and pixel capture
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cur_row    = row_q;
    cur_col    = col_q;
    s1_valid_d = 1'b0;
    s1_l_d     = s1_l_q;
    s1_r_d     = s1_r_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
    s1_eof_d   = 1'b0;
    s1_err_d   = 1'b0;
    if (i_valid && (i_sof || state_q != IDLE)) begin
      if (i_sof) begin
        cur_row  = 16'd0;
        cur_col  = 16'd0;
        s1_err_d = (state_q != IDLE);
        state_d  = FILL;
      end
      s1_valid_d = 1'b1;
      s1_l_d     = i_left_pix;
      s1_r_d     = i_right_pix;
      s1_row_d   = cur_row;
      s1_col_d   = cur_col;
      if (cur_col == 16'(IMG_W - 1)) begin
        col_d = 16'd0;
        row_d = cur_row + 16'd1;
      end else begin
        col_d = cur_col + 16'd1;
        row_d = cur_row;
      end
      if (cur_row == 16'(IMG_H - 1) && cur_col == 16'(IMG_W - 1)) begin
        s1_eof_d = 1'b1;
        state_d  = IDLE;
        row_d    = 16'd0;
        col_d    = 16'd0;
      end else if (state_d == FILL && cur_row == 16'(WIN - 1) && cur_col == 16'd0) begin
        state_d = STREAM;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_l_q     <= '0;
      s1_r_q     <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_eof_q   <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      s1_valid_q <= s1_valid_d;
      s1_l_q     <= s1_l_d;
      s1_r_q     <= s1_r_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      s1_eof_q   <= s1_eof_d;
      s1_err_q   <= s1_err_d;
    end
  end

  // Stage 2: assemble the new column, shift the window, gate the output
  always_comb begin
    col_idx = s1_col_q[COL_AW-1:0];
    col_l   = '0;
    col_r   = '0;
    for (int k = 0; k < WIN - 1; k++) begin
      col_l[k*PIX_W +: PIX_W] = lb_l[k][col_idx];
      col_r[k*PIX_W +: PIX_W] = lb_r[k][col_idx];
    end
    col_l[(WIN-1)*PIX_W +: PIX_W] = s1_l_q;
    col_r[(WIN-1)*PIX_W +: PIX_W] = s1_r_q;

    win_l_d = win_l_q;
    win_r_d = win_r_q;
    if (s1_valid_q) begin
      for (int k = 0; k < WIN; k++) begin
        for (int j = 0; j < WIN - 1; j++) begin
          win_l_d[(k*WIN+j)*PIX_W +: PIX_W] = win_l_q[(k*WIN+j+1)*PIX_W +: PIX_W];
          win_r_d[(k*WIN+j)*PIX_W +: PIX_W] = win_r_q[(k*WIN+j+1)*PIX_W +: PIX_W];
        end
        win_l_d[(k*WIN+WIN-1)*PIX_W +: PIX_W] = col_l[k*PIX_W +: PIX_W];
        win_r_d[(k*WIN+WIN-1)*PIX_W +: PIX_W] = col_r[k*PIX_W +: PIX_W];
      end
    end

    // Windows whose left edge would wrap into the previous line are dropped.
    qualify = s1_valid_q && (s1_row_q >= 16'(WIN - 1)) && (s1_col_q >= 16'(WIN - 1));

    out_valid_d = qualify;
    out_eof_d   = s1_valid_q && s1_eof_q;
    out_err_d   = s1_valid_q && s1_err_q;
    out_win_l_d = qualify ? win_l_d : out_win_l_q;
    out_win_r_d = qualify ? win_r_d : out_win_r_q;
    out_row_d   = qualify ? (s1_row_q - 16'(HALF)) : out_row_q;
    out_col_d   = qualify ? (s1_col_q - 16'(HALF)) : out_col_q;
  end

  always_ff @(posedge i_clk) begin
    if (s1_valid_q) begin
      for (int k = 0; k < WIN - 2; k++) begin
        lb_l[k][col_idx] <= lb_l[k+1][col_idx];
        lb_r[k][col_idx] <= lb_r[k+1][col_idx];
      end
      lb_l[WIN-2][col_idx] <= s1_l_q;
      lb_r[WIN-2][col_idx] <= s1_r_q;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_l_q     <= '0;
      win_r_q     <= '0;
      out_win_l_q <= '0;
      out_win_r_q <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      win_l_q     <= win_l_d;
      win_r_q     <= win_r_d;
      out_win_l_q <= out_win_l_d;
      out_win_r_q <= out_win_r_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign o_win_l     = out_win_l_q;
  assign o_win_r     = out_win_r_q;
  assign o_valid     = out_valid_q;
  assign o_row       = out_row_q;
  assign o_col       = out_col_q;
  assign o_eof       = out_eof_q;
  assign o_frame_err = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stereo_window_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_stereo_window_buffer: scoreboard bench for stereo_window_buffer     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_stereo_window_buffer;

  localparam int PW = 8;
  localparam int W  = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int WB = W * W * PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_sof;
  logic [PW-1:0] i_left, i_right;
  logic [WB-1:0] o_win_l, o_win_r;
  logic          o_valid, o_eof, o_frame_err;
  logic [15:0]   o_row, o_col;

  stereo_window_buffer #(.PIX_W(PW), .WIN(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .i_clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof),
    .i_left_pix(i_left), .i_right_pix(i_right),
    .o_win_l(o_win_l), .o_win_r(o_win_r), .o_valid(o_valid),
    .o_row(o_row), .o_col(o_col), .o_eof(o_eof), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   row;
    logic [15:0]   col;
    logic [WB-1:0] wl;
    logic [WB-1:0] wr;
    logic          eof;
    int            cyc;
  } exp_t;

  typedef struct {
    int gap;
    int ab_r;
    int ab_c;
    int nfr;
    int exp_win;
    int exp_eof;
    int exp_err;
  } vec_t;

  exp_t sb[$];
  int   errq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   gap   = 0;
  int   win_seen = 0, eof_seen = 0, err_seen = 0;
  bit   in_frame = 1'b0;
  logic [15:0]   hold_row = '0, hold_col = '0;
  logic [WB-1:0] hold_wl = '0, hold_wr = '0;
  vec_t vt[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (o_valid) begin
      win_seen++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_window: got row=%0d col=%0d at cyc %0d, required no window", o_row, o_col, cyc);
      end else begin
        e = sb.pop_front();
        if (o_row !== e.row || o_col !== e.col || o_win_l !== e.wl || o_win_r !== e.wr ||
            o_eof !== e.eof || cyc != e.cyc) begin
          fails++;
          $display("FAIL window: got row=%0d col=%0d eof=%0b cyc=%0d wl=%h wr=%h, required row=%0d col=%0d eof=%0b cyc=%0d wl=%h wr=%h",
                   o_row, o_col, o_eof, cyc, o_win_l, o_win_r, e.row, e.col, e.eof, e.cyc, e.wl, e.wr);
        end
        hold_row = e.row; hold_col = e.col; hold_wl = e.wl; hold_wr = e.wr;
      end
    end else begin
      tests++;
      if (o_row !== hold_row || o_col !== hold_col || o_win_l !== hold_wl ||
          o_win_r !== hold_wr || o_eof !== 1'b0) begin
        fails++;
        $display("FAIL hold: got row=%0d col=%0d eof=%0b wl=%h, required row=%0d col=%0d eof=0 wl=%h",
                 o_row, o_col, o_eof, o_win_l, hold_row, hold_col, hold_wl);
      end
    end
    if (o_eof) eof_seen++;
    if (o_frame_err) begin
      err_seen++;
      tests++;
      if (errq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_frame_err: got pulse at cyc %0d, required none", cyc);
      end else begin
        ec = errq.pop_front();
        if (ec != cyc) begin
          fails++;
          $display("FAIL frame_err_time: got cyc %0d, required cyc %0d", cyc, ec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic send(input int r, input int c, input bit sof, input bit qual);
    exp_t e;
    while ($urandom_range(0, 99) < gap) begin
      @(posedge clk); #1;
      i_valid = 1'b0; i_sof = 1'b0;
    end
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_sof   = sof;
    i_left  = PW'(r * 16 + c);
    i_right = PW'(r * 16 + c + 1);
    if (sof) begin
      if (in_frame) errq.push_back(cyc + 2);
      in_frame = 1'b1;
    end
    if (qual && r >= W - 1 && c >= W - 1) begin
      e.row = 16'(r - (W - 1) / 2);
      e.col = 16'(c - (W - 1) / 2);
      e.wl  = '0;
      e.wr  = '0;
      for (int k = 0; k < W; k++)
        for (int j = 0; j < W; j++) begin
          e.wl[(k*W+j)*PW +: PW] = PW'((r - (W - 1) + k) * 16 + (c - (W - 1) + j));
          e.wr[(k*W+j)*PW +: PW] = PW'((r - (W - 1) + k) * 16 + (c - (W - 1) + j) + 1);
        end
      e.eof = (r == IH - 1 && c == IW - 1);
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    if (qual && r == IH - 1 && c == IW - 1) in_frame = 1'b0;
  endtask

  // Sends raster pixels from (0,0) up to, but excluding, (stop_r, stop_c).
  task automatic frame(input int stop_r, input int stop_c, input bit use_sof, input bit qual);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        if (r == stop_r && c == stop_c) return;
        send(r, c, use_sof && r == 0 && c == 0, qual);
      end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0 || errq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d windows and %0d errors outstanding, required 0", sb.size(), errq.size());
      sb.delete();
      errq.delete();
    end
  endtask

  task automatic clear_counts();
    win_seen = 0; eof_seen = 0; err_seen = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 128'(o_valid), 128'd0);
    check({tag, "_eof"},   128'(o_eof), 128'd0);
    check({tag, "_err"},   128'(o_frame_err), 128'd0);
    check({tag, "_row"},   128'(o_row), 128'd0);
    check({tag, "_col"},   128'(o_col), 128'd0);
    check({tag, "_win_l"}, 128'(o_win_l), 128'd0);
    check({tag, "_win_r"}, 128'(o_win_r), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{gap: 0,  ab_r: -1, ab_c: -1, nfr: 1, exp_win: 24, exp_eof: 1, exp_err: 0};
    vt[1] = '{gap: 50, ab_r: -1, ab_c: -1, nfr: 1, exp_win: 24, exp_eof: 1, exp_err: 0};
    vt[2] = '{gap: 0,  ab_r: 3,  ab_c: 4,  nfr: 1, exp_win: 32, exp_eof: 1, exp_err: 1};
    vt[3] = '{gap: 0,  ab_r: -1, ab_c: -1, nfr: 2, exp_win: 48, exp_eof: 2, exp_err: 0};
    vt[4] = '{gap: 30, ab_r: 3,  ab_c: 4,  nfr: 1, exp_win: 32, exp_eof: 1, exp_err: 1};

    rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_left = '0; i_right = '0;
    repeat (3) @(posedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pixels without a start-of-frame must be ignored.
    clear_counts();
    frame(IH, 0, 1'b0, 1'b0);
    drain();
    check("no_sof_windows", 128'(win_seen), 128'd0);

    foreach (vt[i]) begin
      clear_counts();
      gap = vt[i].gap;
      if (vt[i].ab_r >= 0) frame(vt[i].ab_r, vt[i].ab_c, 1'b1, 1'b1);
      for (int f = 0; f < vt[i].nfr; f++) frame(IH, 0, 1'b1, 1'b1);
      drain();
      check($sformatf("vec%0d_windows", i), 128'(win_seen), 128'(vt[i].exp_win));
      check($sformatf("vec%0d_eof", i),     128'(eof_seen), 128'(vt[i].exp_eof));
      check($sformatf("vec%0d_err", i),     128'(err_seen), 128'(vt[i].exp_err));
    end

    // Reset in the middle of streaming, then resume without a new frame start.
    gap = 0;
    frame(3, 0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    i_valid = 1'b0; i_sof = 1'b0;
    sb.delete(); errq.delete();
    hold_row = '0; hold_col = '0; hold_wl = '0; hold_wr = '0;
    in_frame = 1'b0;
    check_zero_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_counts();
    for (int r = 3; r < IH; r++)
      for (int c = 0; c < IW; c++) send(r, c, 1'b0, 1'b0);
    drain();
    check("post_reset_windows", 128'(win_seen), 128'd0);
    check("post_reset_eof",     128'(eof_seen), 128'd0);
    clear_counts();
    frame(IH, 0, 1'b1, 1'b1);
    drain();
    check("recover_windows", 128'(win_seen), 128'd24);
    check("recover_eof",     128'(eof_seen), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
